// File: rtl/alu_seq.sv
// alu_seq: sequential ALU stage driving the C bus of the downsampling datapath.
//
// Combines the accumulator operand (A) with the B bus operand (B). Single-cycle
// ops complete at the start edge; MUL (shift-add) and DIV (restoring) iterate one
// radix-2 step per clock for WIDTH clocks. Operands are sampled only at start.
//
// Optional feature: define ALU_DIV_EN to build the iterative divider. Without it,
// opcode 9 completes in one cycle with result 0 and dz_flag set (unsupported).
//
// Ports:
//   clock     system clock, rising-edge active
//   reset     asynchronous, active-high reset
//   start     one-cycle request; latches alu_op, ac_in, bbus_in when idle
//   alu_op    operation code (0..9, 10..15 behave as PASSA)
//   ac_in     accumulator operand A
//   bbus_in   B bus operand B
//   cbus_out  registered result, held until the next completion
//   busy      high while an iterative op is in progress
//   done      one-cycle pulse when cbus_out has been updated
//   z_flag    cbus_out == 0, updated with done
//   dz_flag   last DIV had B == 0 (or DIV unsupported), updated with done
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] bbus_in,
  output logic [WIDTH-1:0] cbus_out,
  output logic             busy,
  output logic             done,
  output logic             z_flag,
  output logic             dz_flag
);

  typedef enum logic [1:0] {StIdle, StIter, StFin} state_e;

  localparam logic [3:0] OpPassA = 4'd0;
  localparam logic [3:0] OpAdd   = 4'd1;
  localparam logic [3:0] OpSub   = 4'd2;
  localparam logic [3:0] OpPassB = 4'd3;
  localparam logic [3:0] OpInc   = 4'd4;
  localparam logic [3:0] OpDec   = 4'd5;
  localparam logic [3:0] OpShl   = 4'd6;
  localparam logic [3:0] OpShr   = 4'd7;
  localparam logic [3:0] OpMul   = 4'd8;
  localparam logic [3:0] OpDiv   = 4'd9;

  localparam logic [CNT_W-1:0] LastStep = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opa_q;  // MUL: shifting multiplicand; DIV: dividend/quotient
  logic [WIDTH-1:0] opb_q;  // MUL: shifting multiplier; DIV: divisor
  logic [WIDTH-1:0] acc_q;  // MUL: partial product; DIV: partial remainder
  logic [CNT_W-1:0] cnt_q;

  // Single-cycle datapath works on the live inputs because it completes at the
  // same edge that samples start.
  logic [WIDTH-1:0] single_res;
  logic             single_dz;
  logic             start_iter;

  always_comb begin
    single_res = ac_in;
    single_dz  = 1'b0;
    start_iter = 1'b0;
    unique case (alu_op)
      OpPassA: single_res = ac_in;
      OpAdd:   single_res = ac_in + bbus_in;
      OpSub:   single_res = ac_in - bbus_in;
      OpPassB: single_res = bbus_in;
      OpInc:   single_res = ac_in + WIDTH'(1);
      OpDec:   single_res = ac_in - WIDTH'(1);
      OpShl:   single_res = ac_in << bbus_in[4:0];
      OpShr:   single_res = ac_in >> bbus_in[4:0];
      OpMul:   start_iter = 1'b1;
`ifdef ALU_DIV_EN
      OpDiv:   start_iter = 1'b1;
`else
      OpDiv: begin
        single_res = '0;
        single_dz  = 1'b1;
      end
`endif
      default: single_res = ac_in;
    endcase
  end

  // One radix-2 step of the iterative ops.
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH-1:0] iter_res;
  logic             iter_dz;

  assign mul_acc_nxt = opb_q[0] ? (acc_q + opa_q) : acc_q;

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             div_ok;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // Remainder stays below the divisor, so WIDTH+1 bits cover the shifted value
  // and the top bit of the difference is the borrow.
  assign rem_sh   = {acc_q, opa_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign div_ok   = ~rem_diff[WIDTH];
  assign rem_nxt  = div_ok ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt  = {opa_q[WIDTH-2:0], div_ok};

  always_comb begin
    iter_res = mul_acc_nxt;
    iter_dz  = 1'b0;
    if (op_q == OpDiv) begin
      iter_dz  = (opb_q == '0);
      iter_res = iter_dz ? '1 : quo_nxt;
    end
  end
`else
  assign iter_res = mul_acc_nxt;
  assign iter_dz  = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      cbus_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      z_flag   <= 1'b0;
      dz_flag  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= alu_op;
            opa_q <= ac_in;
            opb_q <= bbus_in;
            acc_q <= '0;
            cnt_q <= '0;
            if (start_iter) begin
              busy    <= 1'b1;
              state_q <= StIter;
            end else begin
              cbus_out <= single_res;
              z_flag   <= (single_res == '0);
              dz_flag  <= single_dz;
              done     <= 1'b1;
              state_q  <= StFin;
            end
          end
        end
        StIter: begin
          cnt_q <= cnt_q + CNT_W'(1);
`ifdef ALU_DIV_EN
          if (op_q == OpDiv) begin
            acc_q <= rem_nxt;
            opa_q <= quo_nxt;
          end else begin
            acc_q <= mul_acc_nxt;
            opa_q <= opa_q << 1;
            opb_q <= opb_q >> 1;
          end
`else
          acc_q <= mul_acc_nxt;
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
`endif
          if (cnt_q == LastStep) begin
            cbus_out <= iter_res;
            z_flag   <= (iter_res == '0);
            dz_flag  <= iter_dz;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StFin;
          end
        end
        StFin: begin
          // start here is deliberately dropped; the next op needs an idle cycle.
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
